ship_placer: RTL and testbench

//  Writer side of the ship register: takes one placement command per ship (row, col, orientation),

---
 rtl/ship_placer_pkg.sv | 36 +++
 rtl/ship_placer_if.sv | 33 +++
 rtl/ship_placer_cell_gen.sv | 21 ++
 rtl/ship_placer.sv | 189 ++++++++++++++++++
 tb/tb_ship_placer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ship_placer_pkg.sv
`default_nettype none
//==== ship_placer_pkg : board geometry, cell encoding, ship lengths and placer enums. Rev 1.0 ====
package ship_placer_pkg;

  localparam int NUM_SHIPS  = 5;
  localparam int BOARD_ROWS = 5;
  localparam int BOARD_COLS = 5;
  localparam int CELL_W     = 5;
  localparam int NUM_CELLS  = BOARD_ROWS * BOARD_COLS;
  localparam int MAX_LEN    = NUM_SHIPS;

  typedef enum logic [1:0] {
    REJ_NONE    = 2'd0,
    REJ_BOUNDS  = 2'd1,
    REJ_OVERLAP = 2'd2
  } reject_code_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CMD = 3'd1,
    S_CHECK    = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } placer_state_e;

  // Ship k occupies k+1 cells.
  function automatic logic [2:0] ship_len(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

  function automatic logic [CELL_W-1:0] cell_code(input logic [2:0] row, input logic [2:0] col);
    return CELL_W'(row) * CELL_W'(BOARD_COLS) + CELL_W'(col) + CELL_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ship_placer_if.sv
`default_nettype none
//==== ship_placer_if : command, status and ship-register write port of the placer. Rev 1.0 ====
interface ship_placer_if;
  import ship_placer_pkg::*;

  logic              start;
  logic [2:0]        num_ships;
  logic              place_valid;
  logic              place_ready;
  logic [2:0]        place_row;
  logic [2:0]        place_col;
  logic              place_vert;
  logic [2:0]        cur_ship;
  logic              wr_en;
  logic [2:0]        wr_ship;
  logic [2:0]        wr_slot;
  logic [CELL_W-1:0] wr_cell;
  logic              reject;
  logic [1:0]        reject_code;
  logic              done;

  modport master (
    output start, num_ships, place_valid, place_row, place_col, place_vert,
    input  place_ready, cur_ship, wr_en, wr_ship, wr_slot, wr_cell, reject, reject_code, done
  );

  modport slave (
    input  start, num_ships, place_valid, place_row, place_col, place_vert,
    output place_ready, cur_ship, wr_en, wr_ship, wr_slot, wr_cell, reject, reject_code, done
  );

endinterface
`default_nettype wire

// File: rtl/ship_placer_cell_gen.sv
`default_nettype none
//==== ship_placer_cell_gen : cell code of the cell at a given offset from the ship bow. Rev 1.0 ====
module ship_placer_cell_gen
  import ship_placer_pkg::*;
(
  input  logic [2:0]        i_row,
  input  logic [2:0]        i_col,
  input  logic [2:0]        i_off,
  input  logic              i_vert,
  output logic [CELL_W-1:0] o_cell
);

  logic [2:0] w_row;
  logic [2:0] w_col;

  assign w_row  = i_vert ? i_row + i_off : i_row;
  assign w_col  = i_vert ? i_col : i_col + i_off;
  assign o_cell = cell_code(w_row, w_col);

endmodule
`default_nettype wire

// File: rtl/ship_placer.sv
`default_nettype none
//==== ship_placer : validates ship placements against an occupancy map and streams cells
//==== into the ship register, one slot per cycle. Rev 1.0 ====
module ship_placer
  import ship_placer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ship_placer_if.slave io_bus
);

  placer_state_e        r_state,       w_nxt_state;
  logic [2:0]           r_n,           w_nxt_n;
  logic [2:0]           r_cur_ship,    w_nxt_cur_ship;
  logic [2:0]           r_row,         w_nxt_row;
  logic [2:0]           r_col,         w_nxt_col;
  logic                 r_vert,        w_nxt_vert;
  logic [2:0]           r_off,         w_nxt_off;
  logic [2:0]           r_slot,        w_nxt_slot;
  logic [NUM_CELLS-1:0] r_map,         w_nxt_map;
  logic [CELL_W-1:0]    r_wr_cell,     w_nxt_wr_cell;
  reject_code_e         r_reject_code, w_nxt_reject_code;
  logic                 r_reject,      w_nxt_reject;
  logic                 r_wr_en;
  logic                 r_place_ready;
  logic                 r_done;

  logic [2:0]           w_len;
  logic [2:0]           w_n_clamp;
  logic [2:0]           w_wr_off;
  logic [3:0]           w_span_end;
  logic [3:0]           w_fixed;
  logic                 w_oob;
  logic                 w_hit;
  logic [CELL_W-1:0]    w_chk_cell;
  logic [CELL_W-1:0]    w_chk_idx;
  logic [CELL_W-1:0]    w_wr_gen;
  logic [CELL_W-1:0]    w_map_idx;

  assign w_len     = ship_len(r_cur_ship);
  assign w_n_clamp = (io_bus.num_ships > 3'(NUM_SHIPS)) ? 3'(NUM_SHIPS) : io_bus.num_ships;

  // Far end along the extension axis plus the fixed coordinate, both compared at 4 bits.
  assign w_span_end = (io_bus.place_vert ? {1'b0, io_bus.place_row} : {1'b0, io_bus.place_col})
                    + {1'b0, w_len} - 4'd1;
  assign w_fixed    = io_bus.place_vert ? {1'b0, io_bus.place_col} : {1'b0, io_bus.place_row};
  assign w_oob      = io_bus.place_vert
                    ? ((w_span_end >= 4'(BOARD_ROWS)) || (w_fixed >= 4'(BOARD_COLS)))
                    : ((w_span_end >= 4'(BOARD_COLS)) || (w_fixed >= 4'(BOARD_ROWS)));

  ship_placer_cell_gen u_chk_gen (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_off  (r_off),
    .i_vert (r_vert),
    .o_cell (w_chk_cell)
  );

  // Write generator looks one slot ahead so wr_cell can be registered.
  assign w_wr_off = (r_state == S_WRITE) ? r_slot + 3'd1 : 3'd0;

  ship_placer_cell_gen u_wr_gen (
    .i_row  (r_row),
    .i_col  (r_col),
    .i_off  (w_wr_off),
    .i_vert (r_vert),
    .o_cell (w_wr_gen)
  );

  assign w_chk_idx = w_chk_cell - CELL_W'(1);
  assign w_map_idx = r_wr_cell - CELL_W'(1);
  assign w_hit     = r_map[w_chk_idx];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_n           = r_n;
    w_nxt_cur_ship    = r_cur_ship;
    w_nxt_row         = r_row;
    w_nxt_col         = r_col;
    w_nxt_vert        = r_vert;
    w_nxt_off         = r_off;
    w_nxt_slot        = r_slot;
    w_nxt_map         = r_map;
    w_nxt_reject_code = r_reject_code;
    w_nxt_reject      = 1'b0;
    w_nxt_wr_cell     = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (io_bus.start) begin
          w_nxt_n        = w_n_clamp;
          w_nxt_cur_ship = '0;
          w_nxt_map      = '0;
          w_nxt_state    = (w_n_clamp == 3'd0) ? S_DONE : S_WAIT_CMD;
        end
      end
      S_WAIT_CMD: begin
        if (io_bus.place_valid) begin
          w_nxt_row  = io_bus.place_row;
          w_nxt_col  = io_bus.place_col;
          w_nxt_vert = io_bus.place_vert;
          w_nxt_off  = '0;
          if (w_oob) begin
            w_nxt_reject      = 1'b1;
            w_nxt_reject_code = REJ_BOUNDS;
          end else begin
            w_nxt_reject_code = REJ_NONE;
            w_nxt_state       = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_hit) begin
          w_nxt_reject      = 1'b1;
          w_nxt_reject_code = REJ_OVERLAP;
          w_nxt_state       = S_WAIT_CMD;
        end else if (r_off == w_len - 3'd1) begin
          w_nxt_state   = S_WRITE;
          w_nxt_slot    = '0;
          w_nxt_wr_cell = w_wr_gen;
        end else begin
          w_nxt_off = r_off + 3'd1;
        end
      end
      S_WRITE: begin
        if (r_wr_cell != '0) w_nxt_map[w_map_idx] = 1'b1;
        if (r_slot == 3'(MAX_LEN - 1)) begin
          w_nxt_slot     = '0;
          w_nxt_cur_ship = r_cur_ship + 3'd1;
          w_nxt_state    = (r_cur_ship + 3'd1 == r_n) ? S_DONE : S_WAIT_CMD;
        end else begin
          w_nxt_slot    = r_slot + 3'd1;
          w_nxt_wr_cell = (w_wr_off < w_len) ? w_wr_gen : '0;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n           <= '0;
      r_cur_ship    <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_vert        <= 1'b0;
      r_off         <= '0;
      r_slot        <= '0;
      r_map         <= '0;
      r_wr_cell     <= '0;
      r_reject_code <= REJ_NONE;
      r_reject      <= 1'b0;
      r_wr_en       <= 1'b0;
      r_place_ready <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_n           <= w_nxt_n;
      r_cur_ship    <= w_nxt_cur_ship;
      r_row         <= w_nxt_row;
      r_col         <= w_nxt_col;
      r_vert        <= w_nxt_vert;
      r_off         <= w_nxt_off;
      r_slot        <= w_nxt_slot;
      r_map         <= w_nxt_map;
      r_wr_cell     <= w_nxt_wr_cell;
      r_reject_code <= w_nxt_reject_code;
      r_reject      <= w_nxt_reject;
      r_wr_en       <= (w_nxt_state == S_WRITE);
      r_place_ready <= (w_nxt_state == S_WAIT_CMD);
      r_done        <= (w_nxt_state == S_DONE);
    end
  end

  assign io_bus.place_ready = r_place_ready;
  assign io_bus.cur_ship    = r_cur_ship;
  assign io_bus.wr_en       = r_wr_en;
  assign io_bus.wr_ship     = r_cur_ship;
  assign io_bus.wr_slot     = r_slot;
  assign io_bus.wr_cell     = r_wr_cell;
  assign io_bus.reject      = r_reject;
  assign io_bus.reject_code = r_reject_code;
  assign io_bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ship_placer.sv
`default_nettype none
//==== tb_ship_placer : directed and randomized placement sessions against a board model. Rev 1.0 ====
module tb_ship_placer;
  import ship_placer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ship_placer_if bus();

  ship_placer dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Board model: occupied cells, ship awaiting placement, ships in session.
  bit m_occ[25];
  int m_cur;
  int m_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 25; i++) m_occ[i] = 1'b0;
    m_cur = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_n = 0;
  endtask

  task automatic do_start(input int n);
    bus.start     = 1'b1;
    bus.num_ships = 3'(n);
    @(negedge clk);
    bus.start = 1'b0;
    model_clear();
    m_n = (n > 5) ? 5 : n;
  endtask

  // One placement attempt for the current ship, with every cycle of the response checked.
  task automatic do_place(input int row, input int col, input bit vert);
    int len, code, hit, last, t, slot;
    int cells[5];
    bit exp_wr;
    len  = m_cur + 1;
    code = 0;
    hit  = -1;
    for (int i = 0; i < 5; i++) cells[i] = 0;
    for (int i = 0; i < len; i++) begin
      int r, c;
      r = vert ? row + i : row;
      c = vert ? col : col + i;
      if (r >= 5 || c >= 5) code = 1;
      else begin
        cells[i] = r * 5 + c + 1;
        if (hit < 0 && m_occ[cells[i] - 1]) hit = i;
      end
    end
    if (code == 0 && hit >= 0) code = 2;

    t = 0;
    while (bus.place_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_cmd", bus.place_ready, 1);

    bus.place_row   = 3'(row);
    bus.place_col   = 3'(col);
    bus.place_vert  = vert;
    bus.place_valid = 1'b1;
    @(negedge clk);
    bus.place_valid = 1'b0;

    last = (code == 1) ? 1 : (code == 2) ? hit + 2 : len + 6;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      exp_wr = (code == 0) && (c >= len + 1) && (c <= len + 5);
      check("wr_en", bus.wr_en, exp_wr);
      check("reject", bus.reject, (code != 0) && (c == last));
      if (exp_wr) begin
        slot = c - len - 1;
        check("wr_slot", bus.wr_slot, slot);
        check("wr_ship", bus.wr_ship, m_cur);
        check("wr_cell", bus.wr_cell, (slot < len) ? cells[slot] : 0);
      end
    end
    check("reject_code", bus.reject_code, code);
    if (code == 0) begin
      for (int i = 0; i < len; i++) m_occ[cells[i] - 1] = 1'b1;
      m_cur++;
    end
    check("ready_after", bus.place_ready, (m_cur < m_n));
    check("done", bus.done, (m_cur == m_n));
    check("cur_ship", bus.cur_ship, m_cur);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, wr_cnt;
    bus.start       = 1'b0;
    bus.num_ships   = 3'd0;
    bus.place_valid = 1'b0;
    bus.place_row   = 3'd0;
    bus.place_col   = 3'd0;
    bus.place_vert  = 1'b0;
    m_n = 0;
    m_cur = 0;

    // Reset state
    do_reset();
    check("rst_ready", bus.place_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_done", bus.done, 0);
    check("rst_reject", bus.reject, 0);
    check("rst_code", bus.reject_code, 0);
    check("rst_cur_ship", bus.cur_ship, 0);

    // 1: single one-cell ship at (2,3) -> cell 14
    do_start(1);
    do_place(2, 3, 0);

    // 2: overlap reject and retry; start ignored in WAIT_CMD
    do_start(2);
    do_place(0, 0, 0);
    bus.start = 1'b1;
    bus.num_ships = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_in_wait_cur", bus.cur_ship, 1);
    check("start_in_wait_ready", bus.place_ready, 1);
    check("start_in_wait_reject", bus.reject, 0);
    check("start_in_wait_done", bus.done, 0);
    do_place(0, 0, 1);
    do_place(1, 0, 1);

    // 3: full session, ship 4 out of bounds then along the bottom row
    do_start(5);
    do_place(0, 0, 0);
    do_place(1, 0, 0);
    do_place(2, 0, 0);
    do_place(3, 0, 0);
    do_place(0, 1, 0);
    do_place(4, 0, 0);

    // 4: reset while writing slot 2
    do_reset();
    do_start(1);
    bus.place_row   = 3'd2;
    bus.place_col   = 3'd3;
    bus.place_vert  = 1'b0;
    bus.place_valid = 1'b1;
    @(negedge clk);
    bus.place_valid = 1'b0;
    t = 0;
    while (!(bus.wr_en === 1'b1 && bus.wr_slot === 3'd2) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach_slot2", bus.wr_slot, 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wr_en", bus.wr_en, 0);
    check("abort_ready", bus.place_ready, 0);
    check("abort_done", bus.done, 0);
    check("abort_cur_ship", bus.cur_ship, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", bus.place_ready, 0);
    model_clear();
    do_start(1);
    do_place(2, 3, 0);

    // 5: num_ships=0 completes at once
    do_reset();
    check("zero_done_before", bus.done, 0);
    do_start(0);
    check("zero_done", bus.done, 1);
    check("zero_wr_en", bus.wr_en, 0);
    check("zero_ready", bus.place_ready, 0);

    // 6: place_valid held through WRITE into DONE
    do_reset();
    do_start(1);
    bus.place_row   = 3'd0;
    bus.place_col   = 3'd0;
    bus.place_vert  = 1'b0;
    bus.place_valid = 1'b1;
    wr_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) wr_cnt++;
      check("held_valid_reject", bus.reject, 0);
    end
    bus.place_valid = 1'b0;
    check("held_valid_wr_cnt", wr_cnt, 5);
    check("held_valid_done", bus.done, 1);
    check("held_valid_cur", bus.cur_ship, 1);
    check("held_valid_code", bus.reject_code, 0);

    // Randomized sessions; the first also exercises the num_ships clamp
    for (int s = 0; s < 3; s++) begin
      do_reset();
      do_start((s == 0) ? 7 : int'($urandom_range(1, 7)));
      for (int a = 0; a < 80 && m_cur < m_n; a++)
        do_place(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
